race_controller: RTL and testbench

- Top-level game sequencer that sits beside two PhysicsEngine instances.
- Drives the shared 3-bit `state` bus (RACE = 3'd4 enables physics) and a one-cycle `round_rst` pulse that re-seeds car positions.
- Consumes each car's `pos_x`/`pos_y` to track lap progress, decide the winner and time the race.
- Drives the HUD with the countdown digit, lap counts, winner code and race time.

---
 rtl/race_controller.sv | 179 +++++++++++++++++
 tb/tb_race_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/race_controller.sv
// Game sequencer for the two-car race: countdown, lap tracking by quadrant
// progression, winner decision and race timing for the HUD.
module race_controller #(
  parameter int          CLK_FREQ      = 100_000_000,
  parameter logic [3:0]  LAPS          = 4'd3,
  parameter logic [1:0]  COUNTDOWN_SEC = 2'd3,
  parameter logic [9:0]  CX            = 10'd160,
  parameter logic [9:0]  CY            = 10'd120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_btn,
  input  logic [9:0]  p1_x,
  input  logic [9:0]  p1_y,
  input  logic [9:0]  p2_x,
  input  logic [9:0]  p2_y,
  output logic [2:0]  state,
  output logic        round_rst,
  output logic [1:0]  countdown_val,
  output logic [3:0]  p1_lap,
  output logic [3:0]  p2_lap,
  output logic [1:0]  winner,
  output logic [15:0] race_ticks
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_COUNT  = 3'd3,
    S_RACE   = 3'd4,
    S_FINISH = 3'd5
  } state_t;

  localparam logic [20:0] TICK_MAX = 21'(CLK_FREQ / 60);

  state_t      r_state;
  logic        r_round_rst;
  logic [1:0]  r_cd;
  logic [5:0]  r_sub;
  logic [3:0]  r_p1_lap;
  logic [3:0]  r_p2_lap;
  logic [1:0]  r_winner;
  logic [15:0] r_race_ticks;
  logic [20:0] r_tick_cnt;
  logic        r_start_d;
  logic [1:0]  r_q1;
  logic [1:0]  r_q2;
  logic [1:0]  r_q1_prev;
  logic [1:0]  r_q2_prev;
  logic [1:0]  r_p1;
  logic [1:0]  r_p2;

  logic        w_tick;
  logic        w_start_edge;
  logic        w_adv1;
  logic        w_adv2;
  logic        w_lap1_inc;
  logic        w_lap2_inc;
  logic [3:0]  w_lap1_nxt;
  logic [3:0]  w_lap2_nxt;
  logic        w_win1;
  logic        w_win2;

  // Quadrant the car must enter next for step p: TR, BR, BL, TL.
  function automatic logic [1:0] exp_quad(input logic [1:0] p);
    case (p)
      2'd0:    exp_quad = 2'b01;
      2'd1:    exp_quad = 2'b11;
      2'd2:    exp_quad = 2'b10;
      default: exp_quad = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lap_sat_inc(input logic [3:0] lap);
    lap_sat_inc = (lap == 4'hF) ? lap : lap + 4'd1;
  endfunction

  assign w_tick       = (r_tick_cnt == TICK_MAX);
  assign w_start_edge = start_btn & ~r_start_d;

  assign w_adv1     = (r_state == S_RACE) && (r_q1 != r_q1_prev) && (r_q1 == exp_quad(r_p1));
  assign w_adv2     = (r_state == S_RACE) && (r_q2 != r_q2_prev) && (r_q2 == exp_quad(r_p2));
  assign w_lap1_inc = w_adv1 && (r_p1 == 2'd3);
  assign w_lap2_inc = w_adv2 && (r_p2 == 2'd3);
  assign w_lap1_nxt = w_lap1_inc ? lap_sat_inc(r_p1_lap) : r_p1_lap;
  assign w_lap2_nxt = w_lap2_inc ? lap_sat_inc(r_p2_lap) : r_p2_lap;
  assign w_win1     = w_lap1_inc && (w_lap1_nxt == LAPS);
  assign w_win2     = w_lap2_inc && (w_lap2_nxt == LAPS);

  always_ff @(posedge clk) begin
    if (rst) r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else r_tick_cnt <= r_tick_cnt + 21'd1;
  end

  // Sampled through reset so a button held across reset is not seen as a new press.
  always_ff @(posedge clk) begin
    r_start_d <= start_btn;
    r_q1      <= {p1_y >= CY, p1_x >= CX};
    r_q2      <= {p2_y >= CY, p2_x >= CX};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_round_rst  <= 1'b0;
      r_cd         <= '0;
      r_sub        <= '0;
      r_p1_lap     <= '0;
      r_p2_lap     <= '0;
      r_winner     <= '0;
      r_race_ticks <= '0;
      r_q1_prev    <= '0;
      r_q2_prev    <= '0;
      r_p1         <= '0;
      r_p2         <= '0;
    end else begin
      r_round_rst <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_state      <= S_COUNT;
            r_round_rst  <= 1'b1;
            r_cd         <= COUNTDOWN_SEC;
            r_sub        <= '0;
            r_p1_lap     <= '0;
            r_p2_lap     <= '0;
            r_winner     <= '0;
            r_race_ticks <= '0;
            r_p1         <= '0;
            r_p2         <= '0;
            r_q1_prev    <= r_q1;
            r_q2_prev    <= r_q2;
          end
        end
        S_COUNT: begin
          if (w_tick) begin
            if (r_sub == 6'd59) begin
              r_sub <= '0;
              if (r_cd == 2'd1) begin
                r_cd    <= '0;
                r_state <= S_RACE;
              end else begin
                r_cd <= r_cd - 2'd1;
              end
            end else begin
              r_sub <= r_sub + 6'd1;
            end
          end
        end
        S_RACE: begin
          r_q1_prev <= r_q1;
          r_q2_prev <= r_q2;
          if (w_adv1) r_p1 <= r_p1 + 2'd1;
          if (w_adv2) r_p2 <= r_p2 + 2'd1;
          r_p1_lap <= w_lap1_nxt;
          r_p2_lap <= w_lap2_nxt;
          if (w_tick && (r_race_ticks != 16'hFFFF)) r_race_ticks <= r_race_ticks + 16'd1;
          if (w_win1 || w_win2) begin
            r_state  <= S_FINISH;
            r_winner <= {w_win2, w_win1};
          end
        end
        S_FINISH: begin
          if (w_start_edge) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign state         = r_state;
  assign round_rst     = r_round_rst;
  assign countdown_val = r_cd;
  assign p1_lap        = r_p1_lap;
  assign p2_lap        = r_p2_lap;
  assign winner        = r_winner;
  assign race_ticks    = r_race_ticks;

endmodule

// File: tb/tb_race_controller.sv
// Directed bench for race_controller: one instance with LAPS=3, one with LAPS=1
// for the tie/finish/restart sequence; game tick every 11 cycles.
module tb_race_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_btn, b_start;
  logic [9:0]  p1_x, p1_y, p2_x, p2_y;
  logic [9:0]  b_p1_x, b_p1_y, b_p2_x, b_p2_y;
  logic [2:0]  state, b_state;
  logic        round_rst, b_round_rst;
  logic [1:0]  cd, b_cd;
  logic [3:0]  p1_lap, p2_lap, b_p1_lap, b_p2_lap;
  logic [1:0]  winner, b_winner;
  logic [15:0] race_ticks, b_race_ticks;

  int checks = 0;
  int errors = 0;
  int mcnt   = 0;
  int ntick  = 0;

  race_controller #(.CLK_FREQ(600), .LAPS(4'd3), .COUNTDOWN_SEC(2'd3)) u_dut (
    .clk(clk), .rst(rst), .start_btn(start_btn),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .state(state), .round_rst(round_rst), .countdown_val(cd),
    .p1_lap(p1_lap), .p2_lap(p2_lap), .winner(winner), .race_ticks(race_ticks)
  );

  race_controller #(.CLK_FREQ(600), .LAPS(4'd1), .COUNTDOWN_SEC(2'd3)) u_dut1 (
    .clk(clk), .rst(rst), .start_btn(b_start),
    .p1_x(b_p1_x), .p1_y(b_p1_y), .p2_x(b_p2_x), .p2_y(b_p2_y),
    .state(b_state), .round_rst(b_round_rst), .countdown_val(b_cd),
    .p1_lap(b_p1_lap), .p2_lap(b_p2_lap), .winner(b_winner), .race_ticks(b_race_ticks)
  );

  always #5 clk = ~clk;

  // Reference game-tick counter: period CLK_FREQ/60 + 1 = 11 cycles.
  always @(posedge clk) begin
    if (rst) mcnt <= 0;
    else if (mcnt == 10) begin
      mcnt  <= 0;
      ntick <= ntick + 1;
    end else mcnt <= mcnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ntick(input int target);
    int g;
    g = 0;
    while (ntick < target && g < 4000) begin
      step();
      g++;
    end
    check("tick_wait", ntick, target);
  endtask

  task automatic move1(input logic [9:0] x, input logic [9:0] y);
    p1_x = x; p1_y = y;
    repeat (3) step();
  endtask

  task automatic bmove(input logic [9:0] x1, input logic [9:0] y1,
                       input logic [9:0] x2, input logic [9:0] y2);
    b_p1_x = x1; b_p1_y = y1; b_p2_x = x2; b_p2_y = y2;
    repeat (3) step();
  endtask

  initial begin
    int n0, m0, pulses, rt;
    rst = 1'b1; start_btn = 1'b0; b_start = 1'b0;
    p1_x = 10'd0; p1_y = 10'd130; p2_x = 10'd0; p2_y = 10'd130;
    b_p1_x = 10'd0; b_p1_y = 10'd100; b_p2_x = 10'd0; b_p2_y = 10'd100;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_state", state, 0);
    check("rst_round_rst", round_rst, 0);
    check("rst_cd", cd, 0);
    check("rst_laps", {p1_lap, p2_lap}, 0);
    check("rst_winner", winner, 0);
    check("rst_race_ticks", race_ticks, 0);
    check("rst_b_state", b_state, 0);

    // Held button: exactly one round_rst pulse
    start_btn = 1'b1;
    pulses = 0;
    n0 = ntick;
    for (int i = 0; i < 50; i++) begin
      step();
      if (round_rst) begin
        if (pulses == 0) begin
          n0 = ntick;
          check("entry_state", state, 3);
          check("entry_cd", cd, 3);
        end
        pulses++;
      end
    end
    start_btn = 1'b0;
    check("rr_pulses", pulses, 1);

    wait_ntick(n0 + 59);  check("cd_t59", cd, 3);
    wait_ntick(n0 + 60);  check("cd_t60", cd, 2);
    wait_ntick(n0 + 120); check("cd_t120", cd, 1);
    wait_ntick(n0 + 179); check("cd_t179_state", state, 3);
    check("cd_t179_cd", cd, 1);
    wait_ntick(n0 + 180); check("race_state", state, 4);
    check("race_cd", cd, 0);
    check("race_ticks0", race_ticks, 0);
    wait_ntick(n0 + 183); check("race_ticks3", race_ticks, 3);

    // Car1 lap with an ignored BL->TL start and a TR->TL->TR backtrack
    move1(10'd0, 10'd100);   check("lap_tl0", p1_lap, 0);
    move1(10'd200, 10'd100);
    move1(10'd0, 10'd100);
    move1(10'd200, 10'd100); check("lap_backtrack", p1_lap, 0);
    move1(10'd200, 10'd200);
    move1(10'd50, 10'd200);  check("lap_bl", p1_lap, 0);
    move1(10'd50, 10'd100);  check("lap1", p1_lap, 1);
    check("lap1_p2", p2_lap, 0);
    check("lap1_state", state, 4);
    check("race_ticks_run", race_ticks, ntick - (n0 + 180));
    move1(10'd200, 10'd100);
    move1(10'd200, 10'd200);
    move1(10'd50, 10'd200);
    move1(10'd50, 10'd100);  check("lap2", p1_lap, 2);
    check("lap2_winner", winner, 0);

    // Reset mid-race with button held across the reset edge
    start_btn = 1'b1;
    step();
    check("race_ignores_start", state, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_state", state, 0);
    check("mid_rst_laps", {p1_lap, p2_lap}, 0);
    check("mid_rst_ticks", race_ticks, 0);
    check("mid_rst_cd_win", {cd, winner}, 0);
    check("mid_rst_round_rst", round_rst, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (round_rst) pulses++;
    end
    start_btn = 1'b0;
    check("held_no_countdown", state, 0);
    check("held_no_pulse", pulses, 0);

    // LAPS=1 instance: tie, frozen winner, finish and restart
    b_start = 1'b1;
    m0 = ntick;
    for (int i = 0; i < 3; i++) begin
      step();
      if (b_round_rst) m0 = ntick;
    end
    b_start = 1'b0;
    check("b_entry_state", b_state, 3);
    wait_ntick(m0 + 180);
    check("b_race", b_state, 4);
    bmove(10'd200, 10'd100, 10'd200, 10'd100);
    bmove(10'd200, 10'd200, 10'd200, 10'd200);
    bmove(10'd50, 10'd200, 10'd50, 10'd200);
    b_p1_x = 10'd50; b_p1_y = 10'd100; b_p2_x = 10'd50; b_p2_y = 10'd100;
    step();
    check("tie_pre_state", b_state, 4);
    step();
    check("tie_state", b_state, 5);
    check("tie_winner", b_winner, 3);
    check("tie_laps", {b_p1_lap, b_p2_lap}, 8'h11);
    check("tie_race_ticks", b_race_ticks, ntick - (m0 + 180));
    rt = b_race_ticks;
    bmove(10'd200, 10'd100, 10'd50, 10'd100);
    bmove(10'd200, 10'd200, 10'd50, 10'd100);
    bmove(10'd50, 10'd200, 10'd50, 10'd100);
    bmove(10'd50, 10'd100, 10'd50, 10'd100);
    check("fin_winner_frozen", b_winner, 3);
    check("fin_lap_frozen", b_p1_lap, 1);
    check("fin_ticks_held", b_race_ticks, rt);

    b_start = 1'b1;
    step();
    b_start = 1'b0;
    step();
    check("fin_to_idle", b_state, 0);
    check("idle_ticks_held", b_race_ticks, rt);
    check("idle_winner_held", b_winner, 3);
    b_start = 1'b1;
    step();
    check("restart_rr", b_round_rst, 1);
    check("restart_state", b_state, 3);
    check("restart_cd", b_cd, 3);
    check("restart_ticks", b_race_ticks, 0);
    check("restart_laps", {b_p1_lap, b_p2_lap}, 0);
    check("restart_winner", b_winner, 0);
    b_start = 1'b0;
    step();
    check("restart_rr_one", b_round_rst, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
